// File: rtl/scheduler_pkg.sv
// rtl/scheduler_pkg.sv - shared scheduler types, counter width and saturating increment
package scheduler_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_t;

  localparam int CNT_W = 16;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/task_insert_arbiter_rr_picker.sv
// rtl/task_insert_arbiter_rr_picker.sv - combinational round-robin winner search
module rr_picker #(
  parameter int N_REQ = 4,
  parameter int IDW   = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDW-1:0]   i_ptr,
  output logic [IDW-1:0]   o_winner,
  output logic             o_any
);

  logic [N_REQ-1:0] w_rot;
  logic [IDW-1:0]   w_off;

  // Rotate so ptr lands at bit 0; N_REQ is a power of two so IDW-bit adds wrap for free.
  always_comb begin
    w_rot = '0;
    for (int k = 0; k < N_REQ; k++) begin
      logic [IDW-1:0] idx;
      idx      = IDW'(k) + i_ptr;
      w_rot[k] = i_req[idx];
    end
  end

  always_comb begin
    w_off = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (w_rot[k]) w_off = IDW'(k);
    end
  end

  assign o_winner = w_off + i_ptr;
  assign o_any    = |i_req;

endmodule

// File: rtl/task_insert_arbiter.sv
// rtl/task_insert_arbiter.sv - round-robin arbiter feeding the main-queue insertion port
module task_insert_arbiter
  import scheduler_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int TW      = 32,
  parameter int TIMEOUT = 64,
  parameter int IDW     = $clog2(N_REQ)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [N_REQ*TW-1:0] req_task,
  output logic [N_REQ-1:0]    req_ready,
  input  logic                mq_active,
  input  logic                subtract,
  output logic                ins_valid,
  output logic [TW-1:0]       ins_task,
  input  logic                ins_ready,
  output logic [IDW-1:0]      grant_id,
  output logic [CNT_W-1:0]    ins_count,
  output logic                drop
);

  localparam int WW = $clog2(TIMEOUT + 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDW-1:0]   r_ptr;
  logic [TW-1:0]    r_ins_task;
  logic [IDW-1:0]   r_grant_id;
  logic [CNT_W-1:0] r_ins_count;
  logic [WW-1:0]    r_wait;

  logic             w_window;
  logic [IDW-1:0]   w_winner;
  logic             w_any;
  logic             w_accept;
  logic             w_done;
  logic             w_timeout;

  assign w_window = mq_active & ~subtract;

  rr_picker #(
    .N_REQ (N_REQ),
    .IDW   (IDW)
  ) u_picker (
    .i_req    (req_valid),
    .i_ptr    (r_ptr),
    .o_winner (w_winner),
    .o_any    (w_any)
  );

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = '0;
    w_accept    = 1'b0;
    w_done      = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_window && w_any) begin
          req_ready[w_winner] = 1'b1;
          w_accept            = 1'b1;
          w_state_nxt         = S_SEND;
        end
      end
      S_SEND: begin
        // A closing window does not abort an in-flight task.
        if (ins_ready) begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (r_wait == WW'(TIMEOUT - 1)) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ins_task <= '0;
      r_grant_id <= '0;
      r_wait     <= '0;
    end else if (w_accept) begin
      r_ins_task <= req_task[w_winner*TW +: TW];
      r_grant_id <= w_winner;
      r_wait     <= '0;
    end else if (r_state == S_SEND && !w_done && !w_timeout) begin
      r_wait <= r_wait + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_done || w_timeout) begin
      r_ptr <= r_grant_id + 1'b1;
    end
  end

  // The period boundary wins over a completion landing in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ins_count <= '0;
    end else if (subtract) begin
      r_ins_count <= '0;
    end else if (w_done) begin
      r_ins_count <= sat_inc(r_ins_count);
    end
  end

  assign ins_valid = (r_state == S_SEND);
  assign ins_task  = r_ins_task;
  assign grant_id  = r_grant_id;
  assign ins_count = r_ins_count;
  assign drop      = w_timeout;

endmodule

// File: tb/tb_task_insert_arbiter.sv
// tb/tb_task_insert_arbiter.sv - scoreboard bench for task_insert_arbiter
module tb_task_insert_arbiter;

  localparam int N   = 4;
  localparam int TW  = 32;
  localparam int TO  = 64;
  localparam int IDW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*TW-1:0] req_task;
  logic [N-1:0]    req_ready;
  logic            mq_active;
  logic            subtract;
  logic            ins_valid;
  logic [TW-1:0]   ins_task;
  logic            ins_ready;
  logic [IDW-1:0]  grant_id;
  logic [15:0]     ins_count;
  logic            drop;

  task_insert_arbiter #(.N_REQ(N), .TW(TW), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_task  (req_task),
    .req_ready (req_ready),
    .mq_active (mq_active),
    .subtract  (subtract),
    .ins_valid (ins_valid),
    .ins_task  (ins_task),
    .ins_ready (ins_ready),
    .grant_id  (grant_id),
    .ins_count (ins_count),
    .drop      (drop)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state, advanced at each falling edge to what the next rising edge does.
  int            sb_id[$];
  logic [TW-1:0] sb_task[$];
  int            g_hist[$];
  int            m_ptr   = 0;
  bit            m_busy  = 0;
  int            m_wait  = 0;
  logic [15:0]   m_count = '0;
  int            n_drops = 0;

  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      sb_id.delete();
      sb_task.delete();
      m_ptr   = 0;
      m_busy  = 0;
      m_wait  = 0;
      m_count = '0;
    end else begin
      logic [N-1:0] exp_rdy;
      int w;
      if (drop) n_drops++;
      check_val("mon_count", 64'(ins_count), 64'(m_count));
      check_val("mon_ins_valid", 64'(ins_valid), 64'(m_busy));
      if (!m_busy) begin
        exp_rdy = '0;
        check_val("mon_drop_idle", 64'(drop), 64'd0);
        if (mq_active && !subtract && (|req_valid)) begin
          w = pick(req_valid, m_ptr);
          exp_rdy[w] = 1'b1;
          sb_id.push_back(w);
          sb_task.push_back(req_task[w*TW +: TW]);
          m_busy = 1;
          m_wait = 0;
        end
        check_val("mon_req_ready", 64'(req_ready), 64'(exp_rdy));
      end else if (sb_id.size() == 0) begin
        check_val("mon_sb_empty", 64'd0, 64'd1);
        m_busy = 0;
      end else begin
        check_val("mon_req_ready_busy", 64'(req_ready), 64'd0);
        check_val("mon_task", 64'(ins_task), 64'(sb_task[0]));
        check_val("mon_grant", 64'(grant_id), 64'(sb_id[0]));
        if (ins_ready) begin
          check_val("mon_drop_done", 64'(drop), 64'd0);
          g_hist.push_back(sb_id[0]);
          m_ptr = (sb_id[0] + 1) % N;
          if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
          void'(sb_id.pop_front());
          void'(sb_task.pop_front());
          m_busy = 0;
        end else if (m_wait == TO - 1) begin
          check_val("mon_drop_timeout", 64'(drop), 64'd1);
          m_ptr = (sb_id[0] + 1) % N;
          void'(sb_id.pop_front());
          void'(sb_task.pop_front());
          m_busy = 0;
        end else begin
          check_val("mon_drop_wait", 64'(drop), 64'd0);
          m_wait++;
        end
      end
      if (subtract) m_count = '0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_seq[5];
    exp_seq = '{0, 1, 2, 3, 0};
    rst       = 1'b1;
    req_valid = '0;
    mq_active = 1'b0;
    subtract  = 1'b0;
    ins_ready = 1'b0;
    for (int i = 0; i < N; i++) req_task[i*TW +: TW] = 32'hC0DE_0000 + 32'(i);
    req_task[2*TW +: TW] = 32'h0000_00A5;
    tick();
    tick();
    rst = 1'b0;
    #1;
    check_val("rst_ins_valid", 64'(ins_valid), 64'd0);
    check_val("rst_ins_task", 64'(ins_task), 64'd0);
    check_val("rst_grant", 64'(grant_id), 64'd0);
    check_val("rst_count", 64'(ins_count), 64'd0);
    check_val("rst_drop", 64'(drop), 64'd0);

    // single requester
    tick();
    mq_active = 1'b1;
    ins_ready = 1'b1;
    req_valid = 4'b0100;
    #1;
    check_val("t1_ready", 64'(req_ready), 64'b0100);
    tick();
    req_valid = '0;
    check_val("t1_valid", 64'(ins_valid), 64'd1);
    check_val("t1_task", 64'(ins_task), 64'hA5);
    check_val("t1_grant", 64'(grant_id), 64'd2);
    tick();
    check_val("t1_count", 64'(ins_count), 64'd1);
    req_valid = 4'b1101;
    #1;
    check_val("t1_next_ptr", 64'(req_ready), 64'b1000);
    req_valid = '0;

    // fairness from ptr=0
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    g_hist.delete();
    req_valid = 4'b1111;
    repeat (10) tick();
    req_valid = '0;
    check_val("t2_count", 64'(ins_count), 64'd5);
    check_val("t2_hist_len", 64'(g_hist.size()), 64'd5);
    for (int i = 0; i < 5 && i < g_hist.size(); i++)
      check_val("t2_grant_seq", 64'(g_hist[i]), 64'(exp_seq[i]));

    // window gating
    mq_active = 1'b0;
    req_valid = 4'b0010;
    repeat (5) begin
      tick();
      check_val("t3_closed", 64'(req_ready), 64'd0);
    end
    mq_active = 1'b1;
    #1;
    check_val("t3_open", 64'(req_ready), 64'b0010);
    tick();
    tick();
    subtract = 1'b1;
    #1;
    check_val("t3_sub", 64'(req_ready), 64'd0);
    tick();
    subtract  = 1'b0;
    req_valid = '0;

    // backpressure
    ins_ready = 1'b0;
    req_valid = 4'b1000;
    tick();
    req_valid = '0;
    repeat (10) tick();
    ins_ready = 1'b1;
    tick();
    check_val("t4_count", 64'(ins_count), 64'd1);
    check_val("t4_no_drop", 64'(n_drops), 64'd0);

    // timeout
    ins_ready = 1'b0;
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    repeat (70) tick();
    check_val("t5_drops", 64'(n_drops), 64'd1);
    check_val("t5_count", 64'(ins_count), 64'd1);
    check_val("t5_idle", 64'(ins_valid), 64'd0);
    req_valid = 4'b0011;
    #1;
    check_val("t5_ptr_adv", 64'(req_ready), 64'b0010);
    ins_ready = 1'b1;
    tick();
    req_valid = '0;
    tick();

    // subtract coinciding with a completion
    subtract = 1'b1;
    tick();
    subtract = 1'b0;
    check_val("t6_clear", 64'(ins_count), 64'd0);
    req_valid = 4'b0100;
    repeat (10) tick();
    req_valid = '0;
    check_val("t6_five", 64'(ins_count), 64'd5);
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    subtract  = 1'b1;
    tick();
    subtract = 1'b0;
    check_val("t6_sub_wins", 64'(ins_count), 64'd0);
    check_val("t6_sub_idle", 64'(ins_valid), 64'd0);

    // saturation
    force dut.r_ins_count = 16'hFFFE;
    m_count = 16'hFFFE;
    #1;
    release dut.r_ins_count;
    req_valid = 4'b0100;
    repeat (6) tick();
    req_valid = '0;
    check_val("t6_sat", 64'(ins_count), 64'hFFFF);

    // async reset mid-send
    ins_ready = 1'b0;
    req_valid = 4'b0010;
    tick();
    req_valid = '0;
    tick();
    check_val("t6_in_send", 64'(ins_valid), 64'd1);
    rst = 1'b1;
    #1;
    check_val("t6_rst_valid", 64'(ins_valid), 64'd0);
    check_val("t6_rst_task", 64'(ins_task), 64'd0);
    check_val("t6_rst_grant", 64'(grant_id), 64'd0);
    check_val("t6_rst_count", 64'(ins_count), 64'd0);
    check_val("t6_rst_drop", 64'(drop), 64'd0);
    check_val("t6_rst_ready", 64'(req_ready), 64'd0);
    tick();
    rst = 1'b0;
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/task_insert_arbiter.md
Name: task_insert_arbiter

Overview:
- Round-robin arbiter that shares the main-queue insertion port among N_REQ task sources (task generators, re-insertion from the repair path).
- Accepts tasks only while the period controller keeps the main-queue window open: mq_active=1 and subtract=0.
- Forwards one task at a time over a valid/ready handshake to the insertion cell.
- Counts the insertions made in each period.
- Drops a task whose insertion stalls longer than TIMEOUT cycles.

Parameters:
- N_REQ, 4, number of requesters; must be a power of two, 2..16.
- TW, 32, task record width in bits.
- TIMEOUT, 64, maximum cycles a task may wait for ins_ready before it is dropped; must be at least 1.
- IDW, $clog2(N_REQ), width of grant_id (derived).

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- req_valid  in  N_REQ  per-requester task valid.
- req_task  in  N_REQ*TW  per-requester task; requester i occupies bits [i*TW +: TW].
- req_ready  out  N_REQ  one-hot accept, combinational.
- mq_active  in  1  main-queue window enable from the period controller.
- subtract  in  1  one-cycle period-boundary pulse from the period controller.
- ins_valid  out  1  task presented to the insertion cell.
- ins_task  out  TW  registered task.
- ins_ready  in  1  insertion cell accepts.
- grant_id  out  IDW  index of the requester owning ins_task.
- ins_count  out  16  tasks inserted since the last subtract; saturates at 0xFFFF.
- drop  out  1  one-cycle pulse when a task is discarded on timeout.

Behaviour:
- Reset is rst, asynchronous, active-high; clock is clk.
- Reset values: state=S_IDLE, ptr=0, ins_valid=0, ins_task=0, grant_id=0, ins_count=0, drop=0, wait counter=0.
- window = mq_active & ~subtract.
- S_IDLE:
  - ins_valid=0.
  - If window=1 and |req_valid, the winner is the first requester with req_valid=1, searching from ptr upward with wrap modulo N_REQ.
  - req_ready[winner]=1 in that same cycle (combinational). All other req_ready bits are 0.
  - On the clock edge: ins_task<=winner's task, grant_id<=winner, wait counter<=0, state<=S_SEND.
  - If window=0, req_ready=0 and the state is held.
- S_SEND:
  - ins_valid=1. ins_task and grant_id are held stable. req_ready=0.
  - If ins_ready=1: ins_count<=sat(ins_count+1), ptr<=(grant_id+1) mod N_REQ, state<=S_IDLE.
  - Else if wait counter==TIMEOUT-1: drop=1 for one cycle, ptr<=(grant_id+1) mod N_REQ, state<=S_IDLE. ins_count is unchanged.
  - Otherwise the wait counter increments.
  - The window closing during S_SEND does not abort the transfer; the task still completes or times out.
- Latency and throughput:
  - Accept at cycle t, ins_valid from t+1.
  - Maximum throughput is one task per 2 cycles.
  - A requester is never granted twice in a row while another requester has req_valid=1 (fairness).
- subtract=1 clears ins_count to 0. This takes priority over a simultaneous increment: the completing task is not counted.
- Saturation: ins_count stays at 0xFFFF until the next subtract.
- A requester dropping req_valid before it is accepted is legal. A requester must hold req_task stable while req_valid=1.
- Asserting rst mid-S_SEND clears ins_valid immediately (asynchronously). The in-flight task is lost and nothing is counted.
- No X propagation: ins_task is only loaded from a valid requester.

Decomposition:
- Shared package scheduler_pkg holds:
  - the state enum {S_IDLE, S_SEND};
  - the 16-bit counter width constant;
  - a saturating-increment function.
- Sub-module rr_picker (purely combinational):
  - inputs: req vector and ptr;
  - outputs: winner index and any-valid flag;
  - implemented as a rotate, fixed priority, then un-rotate.
- All state registers live in task_insert_arbiter.

Test Plan:
1. Single requester: mq_active=1, req_valid[2]=1, req_task[2]=0x0000_00A5, ins_ready=1 -> req_ready=4'b0100 at cycle 0; ins_valid=1, ins_task=0xA5, grant_id=2 at cycle 1; ins_count=1; next grant search starts at 3.
2. Fairness: all four req_valid held at 1, ins_ready=1, ptr=0 -> grant_id sequence 0,1,2,3,0 with ins_valid high every other cycle; ins_count=5 after 10 cycles.
3. Window gating: mq_active=0 with req_valid[1]=1 -> req_ready=0 indefinitely. Raise mq_active -> req_ready[1]=1 in that same cycle. Pulse subtract with mq_active=1 -> req_ready=0 in the pulse cycle.
4. Backpressure: ins_ready=0 for 10 cycles, then 1 -> ins_task and grant_id stable for 11 cycles; no drop; ins_count increments once.
5. Timeout: ins_ready held 0 with TIMEOUT=64 -> drop=1 exactly on the 64th S_SEND cycle; ins_valid=0 the next cycle; ins_count unchanged; ptr advanced past the dropped requester.
6. Boundary events:
   - ins_count=5 and subtract coincides with an ins_valid&ins_ready completion -> ins_count=0.
   - ins_count=0xFFFF plus one more insertion -> stays 0xFFFF.
   - rst asserted mid-S_SEND -> ins_valid=0 immediately; all outputs at reset values.
